// File: rtl/imm_gen_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : imm_gen_pipe
//  Purpose  : Pipelined RV32/RV64 immediate generator behind a 2-entry skid
//             buffer, with format code, illegal flag/counter, tag and flush.
//  Revision : 1.0 - initial release
// ============================================================================
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [2:0] c_fmt_none = 3'd0;
  localparam logic [2:0] c_fmt_i    = 3'd1;
  localparam logic [2:0] c_fmt_s    = 3'd2;
  localparam logic [2:0] c_fmt_b    = 3'd3;
  localparam logic [2:0] c_fmt_u    = 3'd4;
  localparam logic [2:0] c_fmt_j    = 3'd5;
  localparam logic [2:0] c_fmt_z    = 3'd6;

  localparam logic [6:0] c_op_load     = 7'b0000011;
  localparam logic [6:0] c_op_misc_mem = 7'b0001111;
  localparam logic [6:0] c_op_imm      = 7'b0010011;
  localparam logic [6:0] c_op_auipc    = 7'b0010111;
  localparam logic [6:0] c_op_imm32    = 7'b0011011;
  localparam logic [6:0] c_op_store    = 7'b0100011;
  localparam logic [6:0] c_op_lui      = 7'b0110111;
  localparam logic [6:0] c_op_branch   = 7'b1100011;
  localparam logic [6:0] c_op_jalr     = 7'b1100111;
  localparam logic [6:0] c_op_jal      = 7'b1101111;
  localparam logic [6:0] c_op_system   = 7'b1110011;

  localparam bit             c_rv64    = (XLEN == 64);
  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

  logic [2:0]      w_fmt;
  logic [31:0]     w_imm32;
  logic [XLEN-1:0] w_imm;
  logic            w_illegal;
  logic            w_accept;
  logic            w_load_out;

  logic             r_out_valid;
  logic [XLEN-1:0]  r_out_imm;
  logic [2:0]       r_out_fmt;
  logic             r_out_illegal;
  logic [TAG_W-1:0] r_out_tag;
  logic             r_skid_valid;
  logic [XLEN-1:0]  r_skid_imm;
  logic [2:0]       r_skid_fmt;
  logic             r_skid_illegal;
  logic [TAG_W-1:0] r_skid_tag;
  logic             r_in_ready;
  logic [CNT_W-1:0] r_cnt;

  // Every immediate is built as 32 bits, sign-extended from bit 31 afterwards.
  always_comb begin
    w_fmt   = c_fmt_none;
    w_imm32 = '0;
    if (in_instr[1:0] == 2'b11) begin
      case (in_instr[6:0])
        c_op_load, c_op_imm, c_op_jalr, c_op_misc_mem: w_fmt = c_fmt_i;
        c_op_imm32:                   w_fmt = c_rv64 ? c_fmt_i : c_fmt_none;
        c_op_store:                   w_fmt = c_fmt_s;
        c_op_branch:                  w_fmt = c_fmt_b;
        c_op_lui, c_op_auipc:         w_fmt = c_fmt_u;
        c_op_jal:                     w_fmt = c_fmt_j;
        c_op_system:                  w_fmt = in_instr[14] ? c_fmt_z : c_fmt_i;
        default:                      w_fmt = c_fmt_none;
      endcase
    end
    case (w_fmt)
      c_fmt_i: w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      c_fmt_s: w_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      c_fmt_b: w_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                          in_instr[30:25], in_instr[11:8], 1'b0};
      c_fmt_u: w_imm32 = {in_instr[31:12], 12'b0};
      c_fmt_j: w_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                          in_instr[20], in_instr[30:21], 1'b0};
      c_fmt_z: w_imm32 = {27'b0, in_instr[19:15]};
      default: w_imm32 = '0;
    endcase
    w_illegal = (w_fmt == c_fmt_none);
  end

  generate
    if (XLEN == 64) begin : g_xlen64
      assign w_imm = {{32{w_imm32[31]}}, w_imm32};
    end else begin : g_xlen32
      assign w_imm = w_imm32;
    end
  endgenerate

  assign w_accept   = in_valid & r_in_ready & ~flush;
  assign w_load_out = ~r_out_valid | out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid    <= 1'b0;
      r_out_imm      <= '0;
      r_out_fmt      <= c_fmt_none;
      r_out_illegal  <= 1'b0;
      r_out_tag      <= '0;
      r_skid_valid   <= 1'b0;
      r_skid_imm     <= '0;
      r_skid_fmt     <= c_fmt_none;
      r_skid_illegal <= 1'b0;
      r_skid_tag     <= '0;
      r_in_ready     <= 1'b1;
    end else if (flush) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
    end else if (w_load_out) begin
      // Skid is full only while in_ready is low, so it never competes with w_accept.
      if (r_skid_valid) begin
        r_out_valid   <= 1'b1;
        r_out_imm     <= r_skid_imm;
        r_out_fmt     <= r_skid_fmt;
        r_out_illegal <= r_skid_illegal;
        r_out_tag     <= r_skid_tag;
        r_skid_valid  <= 1'b0;
        r_in_ready    <= 1'b1;
      end else if (w_accept) begin
        r_out_valid   <= 1'b1;
        r_out_imm     <= w_imm;
        r_out_fmt     <= w_fmt;
        r_out_illegal <= w_illegal;
        r_out_tag     <= in_tag;
      end else begin
        r_out_valid <= 1'b0;
      end
    end else if (w_accept) begin
      r_skid_valid   <= 1'b1;
      r_skid_imm     <= w_imm;
      r_skid_fmt     <= w_fmt;
      r_skid_illegal <= w_illegal;
      r_skid_tag     <= in_tag;
      r_in_ready     <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_accept && w_illegal && (r_cnt != c_cnt_max)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign out_imm     = r_out_imm;
  assign out_fmt     = r_out_fmt;
  assign out_illegal = r_out_illegal;
  assign out_tag     = r_out_tag;
  assign illegal_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_imm_gen_pipe
//  Purpose  : Directed self-checking bench for imm_gen_pipe (RV32, RV64 and a
//             2-bit counter instance driven by one shared stimulus stream).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [4:0]  in_tag;
  logic        out_ready;

  logic        a_in_ready, a_out_valid, a_out_illegal;
  logic [31:0] a_out_imm;
  logic [2:0]  a_out_fmt;
  logic [4:0]  a_out_tag;
  logic [15:0] a_cnt;

  logic        b_in_ready, b_out_valid, b_out_illegal;
  logic [63:0] b_out_imm;
  logic [2:0]  b_out_fmt;
  logic [4:0]  b_out_tag;
  logic [15:0] b_cnt;

  logic        c_in_ready, c_out_valid, c_out_illegal;
  logic [31:0] c_out_imm;
  logic [2:0]  c_out_fmt;
  logic [4:0]  c_out_tag;
  logic [1:0]  c_cnt;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(5), .CNT_W(16)) u_a (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(a_in_ready), .in_instr(in_instr), .in_tag(in_tag),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_imm(a_out_imm),
    .out_fmt(a_out_fmt), .out_illegal(a_out_illegal), .out_tag(a_out_tag),
    .illegal_cnt(a_cnt));

  imm_gen_pipe #(.XLEN(64), .TAG_W(5), .CNT_W(16)) u_b (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(b_in_ready), .in_instr(in_instr), .in_tag(in_tag),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_imm(b_out_imm),
    .out_fmt(b_out_fmt), .out_illegal(b_out_illegal), .out_tag(b_out_tag),
    .illegal_cnt(b_cnt));

  imm_gen_pipe #(.XLEN(32), .TAG_W(5), .CNT_W(2)) u_c (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(c_in_ready), .in_instr(in_instr), .in_tag(in_tag),
    .out_valid(c_out_valid), .out_ready(out_ready), .out_imm(c_out_imm),
    .out_fmt(c_out_fmt), .out_illegal(c_out_illegal), .out_tag(c_out_tag),
    .illegal_cnt(c_cnt));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " a_valid"}, 64'(a_out_valid), 64'd0);
    chk({tag, " a_ready"}, 64'(a_in_ready), 64'd1);
    chk({tag, " a_imm"}, 64'(a_out_imm), 64'd0);
    chk({tag, " a_fmt"}, 64'(a_out_fmt), 64'd0);
    chk({tag, " a_ill"}, 64'(a_out_illegal), 64'd0);
    chk({tag, " a_tag"}, 64'(a_out_tag), 64'd0);
    chk({tag, " a_cnt"}, 64'(a_cnt), 64'd0);
    chk({tag, " b_imm"}, b_out_imm, 64'd0);
    chk({tag, " c_cnt"}, 64'(c_cnt), 64'd0);
  endtask

  logic [31:0] vin  [6];
  logic [31:0] vexp [6];
  logic [2:0]  vfmt [6];

  initial begin
    vin[0] = 32'hFFF00093; vexp[0] = 32'hFFFFFFFF; vfmt[0] = 3'd1;
    vin[1] = 32'hFE20AE23; vexp[1] = 32'hFFFFFFFC; vfmt[1] = 3'd2;
    vin[2] = 32'hFE000CE3; vexp[2] = 32'hFFFFFFF8; vfmt[2] = 3'd3;
    vin[3] = 32'h123452B7; vexp[3] = 32'h12345000; vfmt[3] = 3'd4;
    vin[4] = 32'h001000EF; vexp[4] = 32'h00000800; vfmt[4] = 3'd5;
    vin[5] = 32'h300FD073; vexp[5] = 32'h0000001F; vfmt[5] = 3'd6;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_tag = '0;
    out_ready = 1'b1;
    tick(); tick();
    chk_reset("reset");
    rst_n = 1'b1;
    tick();

    // Back-to-back legal formats, out_ready held high
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_instr = vin[i]; in_tag = 5'(i + 1);
      tick();
      chk($sformatf("b2b%0d valid", i), 64'(a_out_valid), 64'd1);
      chk($sformatf("b2b%0d imm", i), 64'(a_out_imm), 64'(vexp[i]));
      chk($sformatf("b2b%0d fmt", i), 64'(a_out_fmt), 64'(vfmt[i]));
      chk($sformatf("b2b%0d tag", i), 64'(a_out_tag), 64'(i + 1));
      chk($sformatf("b2b%0d imm64", i), b_out_imm, {{32{vexp[i][31]}}, vexp[i]});
    end
    in_valid = 1'b0;
    tick();
    chk("drain valid", 64'(a_out_valid), 64'd0);

    // Illegal encodings and counter saturation
    in_valid = 1'b1; in_instr = 32'h00000000; in_tag = 5'd9;
    tick();
    chk("ill0 fmt", 64'(a_out_fmt), 64'd0);
    chk("ill0 flag", 64'(a_out_illegal), 64'd1);
    chk("ill0 imm", 64'(a_out_imm), 64'd0);
    chk("ill0 cnt", 64'(a_cnt), 64'd1);
    in_instr = 32'h0000007F;
    tick();
    chk("ill7f fmt", 64'(a_out_fmt), 64'd0);
    chk("ill7f flag", 64'(a_out_illegal), 64'd1);
    chk("ill7f cnt", 64'(a_cnt), 64'd2);
    in_instr = 32'h00000000;
    tick();
    chk("ill3 c_cnt", 64'(c_cnt), 64'd3);
    tick(); tick(); tick();
    chk("ill6 a_cnt", 64'(a_cnt), 64'd6);
    chk("ill6 c_cnt sat", 64'(c_cnt), 64'd3);
    chk("ill6 b_cnt", 64'(b_cnt), 64'd6);

    // OP-IMM-32: legal on RV64 only; LUI sign-fill on RV64
    in_instr = 32'h0010009B;
    tick();
    chk("opimm32 b_imm", b_out_imm, 64'h0000000000000001);
    chk("opimm32 b_fmt", 64'(b_out_fmt), 64'd1);
    chk("opimm32 b_ill", 64'(b_out_illegal), 64'd0);
    chk("opimm32 a_ill", 64'(a_out_illegal), 64'd1);
    chk("opimm32 a_fmt", 64'(a_out_fmt), 64'd0);
    chk("opimm32 a_cnt", 64'(a_cnt), 64'd7);
    chk("opimm32 b_cnt", 64'(b_cnt), 64'd6);
    in_instr = 32'h800000B7;
    tick();
    chk("lui64 b_imm", b_out_imm, 64'hFFFFFFFF80000000);
    chk("lui64 a_imm", 64'(a_out_imm), 64'h80000000);
    in_valid = 1'b0;
    tick();

    // Backpressure: tags 1,2,3 offered while out_ready=0
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'hFFF00093; in_tag = 5'd1;
    tick();
    chk("bp1 tag", 64'(a_out_tag), 64'd1);
    chk("bp1 ready", 64'(a_in_ready), 64'd1);
    in_instr = 32'h123452B7; in_tag = 5'd2;
    tick();
    chk("bp2 ready", 64'(a_in_ready), 64'd0);
    chk("bp2 tag stable", 64'(a_out_tag), 64'd1);
    in_instr = 32'h001000EF; in_tag = 5'd3;
    tick();
    chk("bp3 ready", 64'(a_in_ready), 64'd0);
    chk("bp3 imm stable", 64'(a_out_imm), 64'hFFFFFFFF);
    chk("bp3 tag stable", 64'(a_out_tag), 64'd1);
    chk("bp3 c_valid", 64'(c_out_valid), 64'd1);
    out_ready = 1'b1;
    tick();
    chk("bpr2 tag", 64'(a_out_tag), 64'd2);
    chk("bpr2 imm", 64'(a_out_imm), 64'h12345000);
    chk("bpr2 ready", 64'(a_in_ready), 64'd1);
    tick();
    chk("bpr3 tag", 64'(a_out_tag), 64'd3);
    chk("bpr3 imm", 64'(a_out_imm), 64'h00000800);
    chk("bpr3 valid", 64'(a_out_valid), 64'd1);
    in_valid = 1'b0;
    tick();
    chk("bp end valid", 64'(a_out_valid), 64'd0);

    // Flush with both entries full
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'hFE20AE23; in_tag = 5'd4;
    tick();
    in_tag = 5'd5;
    tick();
    chk("fl full ready", 64'(a_in_ready), 64'd0);
    flush = 1'b1; in_tag = 5'd6;
    tick();
    chk("fl valid", 64'(a_out_valid), 64'd0);
    chk("fl ready", 64'(a_in_ready), 64'd1);
    // Flush with in_ready high drops the offered (illegal) word
    in_instr = 32'h00000000; in_tag = 5'd7; out_ready = 1'b1;
    tick();
    chk("fl2 valid", 64'(a_out_valid), 64'd0);
    chk("fl2 cnt", 64'(a_cnt), 64'd7);
    flush = 1'b0; in_valid = 1'b0;
    tick();
    chk("fl after valid", 64'(a_out_valid), 64'd0);
    chk("fl after cnt", 64'(a_cnt), 64'd7);

    // Reset during a stall with a nonzero counter
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h0000007F; in_tag = 5'd10;
    tick();
    in_tag = 5'd11;
    tick();
    chk("rs pre cnt", 64'(a_cnt), 64'd9);
    chk("rs pre ready", 64'(a_in_ready), 64'd0);
    rst_n = 1'b0;
    tick();
    chk_reset("rst stall");
    rst_n = 1'b1; in_valid = 1'b0;
    tick();
    chk("post rst valid", 64'(a_out_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Parametrised, pipelined immediate generator for the decode stage. It accepts one instruction word per valid/ready transfer, decodes its format and produces the XLEN-wide immediate. The result is registered behind a two-entry skid buffer, so fetch and execute can stall independently. Adds features the combinational generator lacks: RV64 support, a CSR-immediate (Z) format, a format code, an illegal-encoding flag and count, a tag pass-through and flush.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64.
TAG_W, 5, width of the sideband tag carried with each instruction.
CNT_W, 16, width of the saturating illegal-encoding counter.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  synchronous, active-low reset.
flush  input  1  synchronous pipeline flush.
in_valid  input  1  upstream has an instruction.
in_ready  output  1  block can accept an instruction.
in_instr  input  32  instruction word.
in_tag  input  TAG_W  sideband tag.
out_valid  output  1  result available.
out_ready  input  1  downstream accepts the result.
out_imm  output  XLEN  decoded immediate.
out_fmt  output  3  format code: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z.
out_illegal  output  1  encoding not recognised.
out_tag  output  TAG_W  tag of the instruction at the output.
illegal_cnt  output  CNT_W  saturating count of accepted illegal encodings.

Behaviour:
- Single clock domain. Reset is synchronous and active-low: rst_n sampled low at a clk edge resets the block.
- Reset values: out_valid=0, skid empty, in_ready=1, out_imm=0, out_fmt=0, out_illegal=0, out_tag=0, illegal_cnt=0. Reset overrides flush and all transfers.
- Decode is combinational on in_instr; its result is captured on acceptance. Acceptance = in_valid & in_ready & ~flush.
- Latency: an instruction accepted at edge N drives the outputs after edge N when the output register is empty or draining. Throughput is 1 per cycle.
- Format decode on opcode in_instr[6:0]. All sign extension is from instr[31] to XLEN bits.
  - I: LOAD 0000011, OP-IMM 0010011, JALR 1100111, MISC-MEM 0001111. OP-IMM-32 0011011 is I only when XLEN=64. imm = sext(instr[31:20]).
  - S: STORE 0100011. imm = sext({instr[31:25], instr[11:7]}).
  - B: BRANCH 1100011. imm = sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - U: LUI 0110111, AUIPC 0010111. imm = sext({instr[31:12], 12'b0}); upper bits are sign-filled when XLEN=64.
  - J: JAL 1101111. imm = sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - SYSTEM 1110011 with instr[14]=1 decodes as Z: imm = zero-extended instr[19:15]. With instr[14]=0 it decodes as I.
  - Any other opcode, or instr[1:0] != 2'b11, decodes as NONE: imm=0, illegal=1.
- Buffering: one output register plus one skid register.
  - in_ready is registered and equals ~skid_valid.
  - If the output is valid and out_ready=0, an accepted instruction goes to the skid register.
  - When the output is taken (out_valid & out_ready), the skid entry, if valid, moves to the output on the same edge. Otherwise the output loads the newly accepted instruction, or clears out_valid if none was accepted.
  - Simultaneous take and accept with an empty skid: the new instruction goes directly to the output.
  - Program order is always preserved.
  - out_* data must hold stable while out_valid=1 and out_ready=0.
- Flush: at the edge it is sampled high, out_valid and the skid valid are cleared and in_ready becomes 1. The input presented in that cycle is dropped. illegal_cnt is not affected.
- illegal_cnt increments by 1 on each accepted instruction that decodes as illegal. It saturates at 2^CNT_W-1 and never wraps. Only reset clears it.
- Reset or flush in the middle of a stall discards both buffered entries. No partial output is ever produced.

Test Plan:
- Reset, out_ready=1, back-to-back XLEN=32 inputs:
  - 0xFFF00093 -> imm 0xFFFFFFFF, fmt 1.
  - 0xFE20AE23 -> 0xFFFFFFFC, fmt 2.
  - 0xFE000CE3 -> 0xFFFFFFF8, fmt 3.
  - 0x123452B7 -> 0x12345000, fmt 4.
  - 0x001000EF -> 0x00000800, fmt 5.
  - 0x300FD073 -> 0x0000001F, fmt 6.
  - Each result appears one cycle after its input, with out_valid held high throughout.
- Backpressure: hold out_ready=0 and offer tags 1, 2, 3 on consecutive cycles -> tags 1 and 2 are accepted and in_ready falls. Release out_ready -> outputs are tags 1, 2, 3 in order with no loss or duplication. Data stays stable while stalled.
- Flush with both entries full -> next cycle out_valid=0 and in_ready=1. The instruction offered during the flush cycle never appears at the output.
- Illegal encodings 0x00000000 and 0x0000007F -> fmt 0, out_illegal=1, imm 0, illegal_cnt increments by 1 each. With CNT_W=2, six illegals -> count stops at 3.
- XLEN=64: 0x800000B7 -> 0xFFFFFFFF80000000. 0x0010009B (OP-IMM-32) -> 0x0000000000000001, fmt 1. The same OP-IMM-32 word at XLEN=32 -> illegal.
- Assert rst_n low during a stall with illegal_cnt > 0 -> all outputs reach reset values at the next edge and in_ready=1.
